dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1: 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pN_req (N=0,1)  input  1  requester N transaction request; held until grant.
REQ-005 SHALL have port pN_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port pN_addr  input  16  word address.
REQ-007 SHALL have port pN_wdata  input  32  store data.
REQ-008 SHALL have port pN_be  input  4  store byte enables; bit i covers bits [8i+7:8i]; ignored for loads.
REQ-009 SHALL have port pN_gnt  output  1  request accepted this cycle; registered inputs captured.
REQ-010 SHALL have port pN_done  output  1  one-cycle completion pulse; load data valid on pN_rdata.
REQ-011 SHALL have port pN_rdata  output  32  load result; holds last value until next load done for that port.
REQ-012 SHALL have port dram_a  output  16  memory word address.
REQ-013 SHALL have port dram_we  output  1  memory write enable, synchronous write.
REQ-014 SHALL have port dram_din  output  32  memory write data.
REQ-015 SHALL have port dram_spo  input  32  memory asynchronous read data; undefined while dram_we=1.
REQ-016 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RD, RMW_RD, WR.
REQ-018 IDLE: pN_gnt SHALL be combinational, asserted only in IDLE, for at most one port per cycle.
REQ-019 Arbitration, FAIR=1: one requester -> granted; both -> the port not granted last; last-grant pointer updates on every grant.
REQ-020 Arbitration, FAIR=0: port 0 SHALL win whenever p0_req=1.
REQ-021 On grant, SHALL latch port id, we, addr, wdata, be; next state: load -> RD; store be=4'hF -> WR; store be in 4'h1..4'hE -> RMW_RD; store be=4'h0 -> IDLE with done, no memory access.
REQ-022 RD: dram_a = latched addr, dram_we=0; SHALL register dram_spo into owner pN_rdata; -> IDLE.
REQ-023 RMW_RD: dram_a = latched addr, dram_we=0; SHALL register merge word = enabled bytes from wdata, others from dram_spo; -> WR.
REQ-024 WR: dram_a = latched addr, dram_we=1 for exactly one cycle, dram_din = wdata (full) or merge word (partial); -> IDLE.
REQ-025 dram_spo SHALL never be sampled in a cycle with dram_we=1.
REQ-026 Outside RD/RMW_RD/WR: dram_we=0, dram_a and dram_din SHALL hold their last values.
REQ-027 pN_done SHALL be registered, asserted for one cycle on the edge leaving RD or WR (or the grant edge for be=0), to the owner port only.
REQ-028 Latency with grant at cycle G: load done at G+2; full store done at G+2 (write at G+1); partial store done at G+3 (write at G+2); be=0 store done at G+1.
REQ-029 A new grant MAY occur in the same cycle a previous done is asserted (back-to-back, IDLE reached).
REQ-030 Request dropped before grant SHALL be ignored; request inputs SHALL be ignored while busy=1.
REQ-031 Same-address load after store completion SHALL return the stored data (no internal caching).

Reset
REQ-032 On rst=1, asynchronously: state=IDLE, pointer=port 0 last-granted-none (port 0 wins first tie), all pN_gnt/pN_done=0, pN_rdata=0, dram_we=0, dram_a=0, dram_din=0, busy=0.
REQ-033 Reset during RMW_RD or WR SHALL abort with no further dram_we and no done pulse.

Verification
REQ-034 Full store then load: p0 store addr 0x0010 data 0xDEADBEEF be 4'hF, then load 0x0010 -> one dram_we pulse, p0_done at G+2, p0_rdata=0xDEADBEEF.
REQ-035 Partial store: mem[0x0020]=0x11223344, p1 store wdata 0xAABBCCDD be 4'b0101 -> dram_din=0x11BB33DD, done at G+3, no spo sample during we.
REQ-036 Contention FAIR=1: both ports continuously request loads -> grants alternate p0,p1,p0,p1; FAIR=0 -> p0 always granted.
REQ-037 be=4'h0 store -> done at G+1, dram_we never asserted.
REQ-038 rst asserted in WR cycle of partial store -> dram_we drops immediately, no done, memory word unchanged, next grant goes to p0 on tie.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter
// Two-port arbiter in front of a single-port DRAM macro with asynchronous
// read and synchronous write. Each requester issues one load or store at a
// time. Partial stores are done as a read-modify-write, so the memory only
// ever sees full-word writes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   pN_req/we/addr/wdata/be  requester N transaction (held until pN_gnt)
//   pN_gnt                   combinational accept, only while idle
//   pN_done                  one-cycle completion pulse
//   pN_rdata                 last load result for port N
//   dram_a/dram_we/dram_din  memory address, write enable, write data
//   dram_spo                 memory asynchronous read data
//   busy                     a transaction is in flight
module dram_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic [15:0] dram_a,
  output logic        dram_we,
  output logic [31:0] dram_din,
  input  logic [31:0] dram_spo,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD     = 2'd1;
  localparam logic [1:0] RMW_RD = 2'd2;
  localparam logic [1:0] WR     = 2'd3;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        last_p1;    // 1 = port 1 was granted most recently
  logic        owner;      // port owning the transaction in flight
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        gnt;
  logic        sel;        // port that wins arbitration this cycle
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        done_now;
  logic        done_port;

  // Enabled bytes from the store data, remaining bytes from memory.
  function automatic logic [31:0] merge_word(input logic [31:0] wd,
                                             input logic [31:0] old,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    // On a tie port 1 wins only in fair mode and only if port 0 went last.
    sel       = p1_req && (!p0_req || ((FAIR != 0) && !last_p1));
    gnt       = (state == IDLE) && !rst && (p0_req || p1_req);
    p0_gnt    = gnt && !sel;
    p1_gnt    = gnt && sel;
    req_we    = sel ? p1_we    : p0_we;
    req_addr  = sel ? p1_addr  : p0_addr;
    req_wdata = sel ? p1_wdata : p0_wdata;
    req_be    = sel ? p1_be    : p0_be;
    busy      = (state != IDLE);

    next_state = state;
    case (state)
      IDLE: begin
        if (gnt) begin
          if (!req_we)               next_state = RD;
          else if (req_be == 4'hF)   next_state = WR;
          else if (req_be == 4'h0)   next_state = IDLE;
          else                       next_state = RMW_RD;
        end
      end
      RD:      next_state = IDLE;
      RMW_RD:  next_state = WR;
      WR:      next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // An empty store completes on its grant edge without touching memory.
    done_now  = 1'b0;
    done_port = owner;
    if (gnt && req_we && (req_be == 4'h0)) begin
      done_now  = 1'b1;
      done_port = sel;
    end else if ((state == RD) || (state == WR)) begin
      done_now  = 1'b1;
      done_port = owner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_p1  <= 1'b1;
      owner    <= 1'b0;
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      dram_a   <= '0;
      dram_we  <= 1'b0;
      dram_din <= '0;
    end else begin
      state   <= next_state;
      // Registered so the write strobe lasts exactly the WR cycle and
      // drops at once on an asynchronous reset.
      dram_we <= (next_state == WR);
      p0_done <= done_now && !done_port;
      p1_done <= done_now && done_port;

      if (gnt) begin
        last_p1 <= sel;
        owner   <= sel;
        if (next_state != IDLE) dram_a <= req_addr;
        if (next_state == WR)   dram_din <= req_wdata;
      end

      if (state == RD) begin
        if (owner) p1_rdata <= dram_spo;
        else       p0_rdata <= dram_spo;
      end

      // Read half of the read-modify-write; dram_we is low here, so the
      // sampled word is valid.
      if (state == RMW_RD) dram_din <= merge_word(wdata_q, dram_spo, be_q);
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) begin
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
// Bench for dram_arbiter. Two instances share the requester inputs: dut runs
// round-robin arbitration, dut_f fixed priority. Each has its own memory
// model; reads return a poison word while the write strobe is high.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [15:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic [3:0]  p0_be = '0, p1_be = '0;

  logic        p0_gnt, p0_done, p1_gnt, p1_done, dram_we, busy;
  logic [31:0] p0_rdata, p1_rdata, dram_din, dram_spo;
  logic [15:0] dram_a;

  logic        p0_gnt_f, p0_done_f, p1_gnt_f, p1_done_f, dram_we_f, busy_f;
  logic [31:0] p0_rdata_f, p1_rdata_f, dram_din_f, dram_spo_f;
  logic [15:0] dram_a_f;

  logic [31:0] mem   [0:65535];
  logic [31:0] mem_f [0:65535];

  localparam logic [31:0] POISON = 32'hDEAD_0BAD;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign dram_spo   = dram_we   ? POISON : mem[dram_a];
  assign dram_spo_f = dram_we_f ? POISON : mem_f[dram_a_f];

  always @(posedge clk) begin
    if (dram_we)   mem[dram_a]     <= dram_din;
    if (dram_we_f) mem_f[dram_a_f] <= dram_din_f;
  end

  dram_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .dram_a(dram_a), .dram_we(dram_we), .dram_din(dram_din), .dram_spo(dram_spo),
    .busy(busy)
  );

  dram_arbiter #(.FAIR(0)) dut_f (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt_f), .p0_done(p0_done_f), .p0_rdata(p0_rdata_f),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt_f), .p1_done(p1_done_f), .p1_rdata(p1_rdata_f),
    .dram_a(dram_a_f), .dram_we(dram_we_f), .dram_din(dram_din_f), .dram_spo(dram_spo_f),
    .busy(busy_f)
  );

  task automatic drive_port(input bit port, input bit req, input bit we,
                            input logic [15:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (!port) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = wd; p0_be = be;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = wd; p1_be = be;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one transaction and records what the DUT did over the next five
  // cycles. Latency k means the pulse was seen k cycles after the grant cycle.
  task automatic run_txn(input bit port, input bit we, input logic [15:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output bit granted, output int done_lat, output int done_cnt,
                         output int other_cnt, output int we_cnt,
                         output logic [31:0] din_w, output logic [15:0] a_w);
    granted = 1'b0; done_lat = -1; done_cnt = 0; other_cnt = 0; we_cnt = 0;
    din_w = '0; a_w = '0;
    @(negedge clk);
    drive_port(port, 1'b1, we, a, wd, be);
    for (int t = 0; t < 8; t++) begin
      #1;
      if ((port ? p1_gnt : p0_gnt) === 1'b1) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!granted) begin
      drive_port(port, 1'b0, we, a, wd, be);
      return;
    end
    @(posedge clk);
    #1;
    drive_port(port, 1'b0, we, a, wd, be);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if ((port ? p1_done : p0_done) === 1'b1) begin
        done_cnt++;
        if (done_lat < 0) done_lat = k;
      end
      if ((port ? p0_done : p1_done) === 1'b1) other_cnt++;
      if (dram_we === 1'b1) begin
        we_cnt++;
        din_w = dram_din;
        a_w   = dram_a;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    p0_req = 1'b1; p1_req = 1'b1;
    #1;
    total++; if (p0_gnt !== 1'b0)   begin bad++; $display("FAIL rst_p0_gnt got=%b exp=0", p0_gnt); end
    total++; if (p1_gnt !== 1'b0)   begin bad++; $display("FAIL rst_p1_gnt got=%b exp=0", p1_gnt); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (p0_done !== 1'b0)  begin bad++; $display("FAIL rst_p0_done got=%b exp=0", p0_done); end
    total++; if (p1_done !== 1'b0)  begin bad++; $display("FAIL rst_p1_done got=%b exp=0", p1_done); end
    total++; if (p0_rdata !== 32'h0) begin bad++; $display("FAIL rst_p0_rdata got=%h exp=0", p0_rdata); end
    total++; if (p1_rdata !== 32'h0) begin bad++; $display("FAIL rst_p1_rdata got=%h exp=0", p1_rdata); end
    total++; if (dram_we !== 1'b0)  begin bad++; $display("FAIL rst_dram_we got=%b exp=0", dram_we); end
    total++; if (dram_a !== 16'h0)  begin bad++; $display("FAIL rst_dram_a got=%h exp=0", dram_a); end
    total++; if (dram_din !== 32'h0) begin bad++; $display("FAIL rst_dram_din got=%h exp=0", dram_din); end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_store_load();
    bit g; int lat, dc, oc, wc; logic [31:0] dw; logic [15:0] aw;
    run_txn(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, g, lat, dc, oc, wc, dw, aw);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL full_st_gnt got=%b exp=1", g); end
    total++; if (lat != 2)   begin bad++; $display("FAIL full_st_lat got=%0d exp=2", lat); end
    total++; if (dc != 1 || oc != 0) begin bad++; $display("FAIL full_st_done_cnt got=%0d/%0d exp=1/0", dc, oc); end
    total++; if (wc != 1)    begin bad++; $display("FAIL full_st_we_cnt got=%0d exp=1", wc); end
    total++; if (dw !== 32'hDEADBEEF || aw !== 16'h0010) begin bad++; $display("FAIL full_st_write got=%h@%h exp=deadbeef@0010", dw, aw); end
    run_txn(1'b0, 1'b0, 16'h0010, 32'h0, 4'h0, g, lat, dc, oc, wc, dw, aw);
    total++; if (lat != 2)   begin bad++; $display("FAIL load_lat got=%0d exp=2", lat); end
    total++; if (wc != 0)    begin bad++; $display("FAIL load_we_cnt got=%0d exp=0", wc); end
    total++; if (p0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", p0_rdata); end
  endtask

  task automatic test_partial_store();
    bit g; int lat, dc, oc, wc; logic [31:0] dw; logic [15:0] aw;
    run_txn(1'b0, 1'b1, 16'h0020, 32'h11223344, 4'hF, g, lat, dc, oc, wc, dw, aw);
    run_txn(1'b1, 1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, g, lat, dc, oc, wc, dw, aw);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL part_gnt got=%b exp=1", g); end
    total++; if (lat != 3)   begin bad++; $display("FAIL part_lat got=%0d exp=3", lat); end
    total++; if (dc != 1 || oc != 0) begin bad++; $display("FAIL part_done_cnt got=%0d/%0d exp=1/0", dc, oc); end
    total++; if (wc != 1)    begin bad++; $display("FAIL part_we_cnt got=%0d exp=1", wc); end
    total++; if (dw !== 32'h11BB33DD) begin bad++; $display("FAIL part_din got=%h exp=11bb33dd", dw); end
    total++; if (mem[16'h0020] !== 32'h11BB33DD) begin bad++; $display("FAIL part_mem got=%h exp=11bb33dd", mem[16'h0020]); end
  endtask

  task automatic test_be_zero();
    bit g; int lat, dc, oc, wc; logic [31:0] dw; logic [15:0] aw;
    run_txn(1'b0, 1'b1, 16'h0040, 32'h01020304, 4'hF, g, lat, dc, oc, wc, dw, aw);
    run_txn(1'b0, 1'b1, 16'h0040, 32'hFFFFFFFF, 4'h0, g, lat, dc, oc, wc, dw, aw);
    total++; if (lat != 1) begin bad++; $display("FAIL be0_lat got=%0d exp=1", lat); end
    total++; if (dc != 1)  begin bad++; $display("FAIL be0_done_cnt got=%0d exp=1", dc); end
    total++; if (wc != 0)  begin bad++; $display("FAIL be0_we_cnt got=%0d exp=0", wc); end
    total++; if (mem[16'h0040] !== 32'h01020304) begin bad++; $display("FAIL be0_mem got=%h exp=01020304", mem[16'h0040]); end
  endtask

  task automatic test_busy_ignore();
    int p1_seen, p0_seen;
    p1_seen = 0; p0_seen = 0;
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    #1;
    total++; if (p0_gnt !== 1'b1) begin bad++; $display("FAIL busy_p0_gnt got=%b exp=1", p0_gnt); end
    @(posedge clk); #1;
    p0_req = 1'b0;
    drive_port(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (busy !== 1'b1 || p1_gnt !== 1'b0) begin bad++; $display("FAIL busy_hold got=busy%b/gnt%b exp=busy1/gnt0", busy, p1_gnt); end
    @(posedge clk); #1;
    p1_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (p1_gnt === 1'b1 || p1_done === 1'b1) p1_seen++;
      if (p0_done === 1'b1) p0_seen++;
    end
    total++; if (p1_seen != 0) begin bad++; $display("FAIL busy_dropped_req got=%0d exp=0", p1_seen); end
    total++; if (p0_seen != 1) begin bad++; $display("FAIL busy_p0_done got=%0d exp=1", p0_seen); end
  endtask

  task automatic test_contention();
    int exp_port, ng, nf, last_c, fixed_bad, both;
    exp_port = 0; ng = 0; nf = 0; last_c = -10; fixed_bad = 0; both = 0;
    apply_reset();
    drive_port(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    drive_port(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
    for (int c = 0; c < 16; c++) begin
      #1;
      if (p0_gnt === 1'b1 && p1_gnt === 1'b1) both++;
      if (p0_gnt === 1'b1 || p1_gnt === 1'b1) begin
        total++;
        if (int'(p1_gnt) != exp_port) begin bad++; $display("FAIL fair_order grant%0d got=p%0d exp=p%0d", ng, int'(p1_gnt), exp_port); end
        if (ng > 0) begin
          total++;
          if (c - last_c != 2) begin bad++; $display("FAIL back_to_back_gap got=%0d exp=2", c - last_c); end
        end
        exp_port = 1 - int'(p1_gnt);
        last_c = c;
        ng++;
      end
      if (p0_gnt_f === 1'b1 || p1_gnt_f === 1'b1) begin
        nf++;
        if (p1_gnt_f === 1'b1) fixed_bad++;
      end
      @(negedge clk);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    total++; if (ng < 7) begin bad++; $display("FAIL fair_grant_count got=%0d exp>=7", ng); end
    total++; if (both != 0) begin bad++; $display("FAIL fair_double_gnt got=%0d exp=0", both); end
    total++; if (nf < 7 || fixed_bad != 0) begin bad++; $display("FAIL fixed_prio got=%0d grants %0d p1 exp>=7 grants 0 p1", nf, fixed_bad); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_in_wr();
    bit g; int lat, dc, oc, wc, dn; logic [31:0] dw; logic [15:0] aw;
    run_txn(1'b0, 1'b1, 16'h0030, 32'h55667788, 4'hF, g, lat, dc, oc, wc, dw, aw);
    @(negedge clk);
    drive_port(1'b1, 1'b1, 1'b1, 16'h0030, 32'hCAFEF00D, 4'b0011);
    #1;
    total++; if (p1_gnt !== 1'b1) begin bad++; $display("FAIL rwr_gnt got=%b exp=1", p1_gnt); end
    @(posedge clk); #1;
    p1_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (dram_we !== 1'b1 || dram_din !== 32'h5566F00D) begin bad++; $display("FAIL rwr_in_wr got=we%b din%h exp=we1 din5566f00d", dram_we, dram_din); end
    rst = 1'b1;
    #1;
    total++; if (dram_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rwr_abort got=we%b busy%b exp=0/0", dram_we, busy); end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      if (p0_done === 1'b1 || p1_done === 1'b1 || dram_we === 1'b1) dn++;
      @(negedge clk);
    end
    total++; if (dn != 0) begin bad++; $display("FAIL rwr_no_done got=%0d exp=0", dn); end
    total++; if (mem[16'h0030] !== 32'h55667788) begin bad++; $display("FAIL rwr_mem got=%h exp=55667788", mem[16'h0030]); end
    drive_port(1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
    drive_port(1'b1, 1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
    #1;
    total++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin bad++; $display("FAIL rwr_tie got=p0%b p1%b exp=p0 1 p1 0", p0_gnt, p1_gnt); end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [0:7];
    logic [31:0] exp_rd  [0:1];
    logic [31:0] mask, exp_word, wd;
    logic [15:0] a;
    logic [3:0]  be;
    bit port, we, g;
    int idx, exp_lat, exp_we, lat, dc, oc, wc, errs;
    logic [31:0] dw; logic [15:0] aw;
    apply_reset();
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      run_txn(i[0], 1'b1, 16'h0100 + 16'(i), ref_mem[i], 4'hF, g, lat, dc, oc, wc, dw, aw);
    end
    errs = 0;
    for (int n = 0; n < 40; n++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 7);
      a    = 16'h0100 + 16'(idx);
      wd   = $urandom;
      case ($urandom_range(0, 3))
        0:       be = 4'h0;
        1:       be = 4'hF;
        default: be = 4'($urandom_range(1, 14));
      endcase
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      exp_word = (ref_mem[idx] & ~mask) | (wd & mask);
      if (!we)              begin exp_lat = 2; exp_we = 0; end
      else if (be == 4'h0)  begin exp_lat = 1; exp_we = 0; end
      else if (be == 4'hF)  begin exp_lat = 2; exp_we = 1; end
      else                  begin exp_lat = 3; exp_we = 1; end
      run_txn(port, we, a, wd, be, g, lat, dc, oc, wc, dw, aw);
      total++;
      if (!g || lat != exp_lat || dc != 1 || oc != 0) begin
        bad++; errs++;
        $display("FAIL rnd%0d_timing got=g%0b lat%0d dc%0d oc%0d exp=g1 lat%0d dc1 oc0", n, g, lat, dc, oc, exp_lat);
      end
      total++;
      if (wc != exp_we) begin bad++; errs++; $display("FAIL rnd%0d_we_cnt got=%0d exp=%0d", n, wc, exp_we); end
      if (we) begin
        if (exp_we == 1) begin
          total++;
          if (dw !== exp_word || aw !== a) begin bad++; errs++; $display("FAIL rnd%0d_write got=%h@%h exp=%h@%h", n, dw, aw, exp_word, a); end
          ref_mem[idx] = exp_word;
        end
        total++;
        if (mem[a] !== ref_mem[idx]) begin bad++; errs++; $display("FAIL rnd%0d_mem got=%h exp=%h", n, mem[a], ref_mem[idx]); end
      end else begin
        exp_rd[port] = ref_mem[idx];
      end
      total++;
      if (p0_rdata !== exp_rd[0] || p1_rdata !== exp_rd[1]) begin
        bad++; errs++;
        $display("FAIL rnd%0d_rdata got=%h/%h exp=%h/%h", n, p0_rdata, p1_rdata, exp_rd[0], exp_rd[1]);
      end
      if (errs > 10) break;
    end
  endtask

  initial begin
    test_reset();
    test_full_store_load();
    test_partial_store();
    test_be_zero();
    test_busy_ignore();
    test_contention();
    test_reset_in_wr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
